set_cond_sequencer: RTL and testbench

//  Sequences one set-on-condition instruction at a time (SEQ/SNE/SLT/SGT/SLE/SGE) through the shared ALU subtractor.

---
 rtl/set_cond_pkg.sv | 44 ++++
 rtl/set_flag_decode.sv | 14 +
 rtl/set_cond_sequencer.sv | 124 ++++++++++++
 tb/tb_set_cond_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_cond_pkg.sv
// Shared definitions for the set-on-condition sequencer: opcodes, FSM state
// encoding and the opcode/flag evaluation used by every set path.
package set_cond_pkg;

    localparam logic [2:0] OP_SEQ = 3'd0;
    localparam logic [2:0] OP_SNE = 3'd1;
    localparam logic [2:0] OP_SLT = 3'd2;
    localparam logic [2:0] OP_SGT = 3'd3;
    localparam logic [2:0] OP_SLE = 3'd4;
    localparam logic [2:0] OP_SGE = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ARB  = S_ARB,
        ST_WAIT = S_WAIT,
        ST_DONE = S_DONE
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_SGE);
    endfunction

    // z = difference is zero, c = carry-out of A + ~B + 1 (A >= B unsigned)
    function automatic logic set_flag(input logic [2:0] op, input logic z, input logic c);
        logic f;
        f = 1'b0;
        case (op)
            OP_SEQ:  f = z;
            OP_SNE:  f = !z;
            OP_SLT:  f = !c;
            OP_SGT:  f = c && !z;
            OP_SLE:  f = !c || z;
            OP_SGE:  f = c;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/set_flag_decode.sv
// Combinational opcode/zero/carry to set-flag decode, shared between the
// sequenced and single-cycle set paths.
module set_flag_decode
    import set_cond_pkg::*;
(
    input  logic [2:0] op,
    input  logic       z,
    input  logic       c,
    output logic       flag
);

    assign flag = set_flag(op, z, c);

endmodule

// File: rtl/set_cond_sequencer.sv
// Runs one set-on-condition instruction at a time through the shared ALU
// subtractor: accept, arbitrate, wait for the difference, return a 0/1 value.
module set_cond_sequencer
    import set_cond_pkg::*;
#(
    parameter int W       = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_sub,
    input  logic             alu_rvalid,
    input  logic [W-1:0]     alu_res,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_set,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt;
    logic             req_legal;
    logic             accept;
    logic             res_z;
    logic             flag;
    logic             wait_last;

    assign req_legal = op_legal(req_op);
    assign accept    = req_valid && (state == ST_IDLE);
    assign res_z     = (alu_res == '0);
    assign wait_last = (cnt == CNT_W'(TIMEOUT - 1));

    set_flag_decode u_flag (
        .op   (op_q),
        .z    (res_z),
        .c    (alu_cout),
        .flag (flag)
    );

    // Handshake outputs are decoded from state so reset removes them at once
    assign req_ready = rst_n && (state == ST_IDLE);
    assign alu_req   = (state == ST_ARB);
    assign alu_sub   = (state == ST_ARB);
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = req_legal ? ST_ARB : ST_DONE;
            ST_ARB:  if (alu_gnt) state_nxt = ST_WAIT;
            ST_WAIT: if (alu_rvalid || wait_last) state_nxt = ST_DONE;
            ST_DONE: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            tag_q   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            cnt     <= '0;
            res_set <= '0;
            res_tag <= '0;
            res_err <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                tag_q <= req_tag;
                alu_a <= req_a;
                alu_b <= req_b;
                if (!req_legal) begin
                    res_set <= '0;
                    res_tag <= req_tag;
                    res_err <= 1'b1;
                end
            end

            cnt <= (state == ST_WAIT) ? cnt + CNT_W'(1) : '0;

            // A result arriving on the final wait cycle still beats the timeout
            if (state == ST_WAIT) begin
                if (alu_rvalid) begin
                    res_set <= W'(flag);
                    res_tag <= tag_q;
                    res_err <= 1'b0;
                end else if (wait_last) begin
                    res_set <= '0;
                    res_tag <= tag_q;
                    res_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_set_cond_sequencer.sv
// Scoreboard bench for set_cond_sequencer: expected results are queued when a
// request is driven and compared when the result handshake happens.
module tb_set_cond_sequencer;

    localparam int W       = 32;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic [TAG_W-1:0] req_tag;
    logic             alu_req;
    logic             alu_gnt;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic             alu_sub;
    logic             alu_rvalid;
    logic [W-1:0]     alu_res;
    logic             alu_cout;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_set;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;

    typedef struct {
        logic [W-1:0]     set;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    set_cond_sequencer #(.W(W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sub    (alu_sub),
        .alu_rvalid (alu_rvalid),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_set    (res_set),
        .res_tag    (res_tag),
        .res_err    (res_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unsigned comparison reference, written from the operand values directly
    function automatic logic ref_flag(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return a < b;
            3'd3:    return a > b;
            3'd4:    return a <= b;
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Result handshake completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_set", res_set, e.set);
                chk("sb_tag", 32'(res_tag), 32'(e.tag));
                chk("sb_err", 32'(res_err), 32'(e.err));
            end
        end
    end

    // rv_dly < 0: ALU never answers; otherwise rvalid after rv_dly idle WAIT cycles
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAG_W-1:0] tag, input int gnt_dly, input int rv_dly,
                         input int rdy_dly);
        exp_t e;
        logic legal;
        legal = (op <= 3'd5);
        e.tag = tag;
        if (!legal || rv_dly < 0) begin
            e.set = '0;
            e.err = 1'b1;
        end else begin
            e.set = W'(ref_flag(op, a, b));
            e.err = 1'b0;
        end
        sb_q.push_back(e);

        chk("idle_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;

        if (!legal) begin
            chk("ill_valid", 32'(res_valid), 32'(1));
            chk("ill_noreq", 32'(alu_req), 32'(0));
        end else begin
            chk("arb_req", 32'(alu_req), 32'(1));
            chk("arb_sub", 32'(alu_sub), 32'(1));
            for (int i = 0; i < gnt_dly; i++) begin
                alu_rvalid = (i == 0);
                alu_res    = '0;
                alu_cout   = 1'b1;
                tick();
                alu_rvalid = 1'b0;
                chk("hold_req", 32'(alu_req), 32'(1));
                chk("hold_a", alu_a, a);
                chk("hold_b", alu_b, b);
                chk("hold_rdy", 32'(req_ready), 32'(0));
            end
            alu_gnt = 1'b1;
            tick();
            alu_gnt = 1'b0;
            chk("wait_req", 32'(alu_req), 32'(0));
            chk("wait_vld", 32'(res_valid), 32'(0));
            if (rv_dly < 0) begin
                for (int i = 0; i < TIMEOUT - 1; i++) tick();
                chk("to_early", 32'(res_valid), 32'(0));
                tick();
            end else begin
                for (int i = 0; i < rv_dly; i++) tick();
                chk("rv_early", 32'(res_valid), 32'(0));
                alu_rvalid = 1'b1;
                alu_res    = a - b;
                alu_cout   = (a >= b);
                tick();
                alu_rvalid = 1'b0;
            end
            chk("done_vld", 32'(res_valid), 32'(1));
        end

        chk("done_busy", 32'(busy), 32'(1));
        for (int i = 0; i < rdy_dly; i++) begin
            req_valid = 1'b1;
            req_op    = 3'd0;
            tick();
            chk("stall_vld", 32'(res_valid), 32'(1));
            chk("stall_set", res_set, e.set);
            chk("stall_tag", 32'(res_tag), 32'(e.tag));
            chk("stall_rdy", 32'(req_ready), 32'(0));
            chk("stall_noreq", 32'(alu_req), 32'(0));
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ret_vld", 32'(res_valid), 32'(0));
        chk("ret_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        alu_gnt    = 1'b0;
        alu_rvalid = 1'b0;
        alu_res    = '0;
        alu_cout   = 1'b0;
        res_ready  = 1'b0;

        #12;
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_areq", 32'(alu_req), 32'(0));
        chk("rst_vld", 32'(res_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_set", res_set, 32'(0));
        chk("rst_a", alu_a, 32'(0));
        #10;
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", 32'(req_ready), 32'(1));

        do_op(3'd0, 32'd5, 32'd5, 4'h3, 0, 0, 0);
        do_op(3'd2, 32'd3, 32'd7, 4'h4, 0, 0, 0);
        do_op(3'd5, 32'd3, 32'd7, 4'h5, 0, 0, 0);
        do_op(3'd3, 32'd7, 32'd3, 4'h6, 0, 0, 0);
        do_op(3'd4, 32'd4, 32'd4, 4'h7, 0, 0, 0);
        do_op(3'd1, 32'd9, 32'd2, 4'h8, 1, 2, 0);
        do_op(3'd0, 32'd1, 32'd2, 4'h9, 0, 1, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'd0, 4'hA, 0, 0, 0);

        do_op(3'd3, 32'd100, 32'd20, 4'hB, 10, 0, 0);

        do_op(3'd2, 32'd1, 32'd2, 4'hC, 0, -1, 0);
        do_op(3'd1, 32'd8, 32'd8, 4'hD, 0, TIMEOUT - 1, 0);

        do_op(3'd7, 32'd1, 32'd1, 4'hE, 0, 0, 0);
        do_op(3'd6, 32'd1, 32'd2, 4'h1, 0, 0, 2);

        do_op(3'd4, 32'd10, 32'd3, 4'h2, 0, 0, 5);

        for (int i = 0; i < 8; i++) begin
            do_op(3'($urandom_range(0, 5)), W'($urandom_range(0, 6)), W'($urandom_range(0, 6)),
                  TAG_W'(i), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while waiting on the ALU drops everything without a result
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd11;
        req_b     = 32'd12;
        req_tag   = 4'h5;
        tick();
        req_valid = 1'b0;
        alu_gnt   = 1'b1;
        tick();
        alu_gnt = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mrst_areq", 32'(alu_req), 32'(0));
        chk("mrst_vld", 32'(res_valid), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_rdy", 32'(req_ready), 32'(0));
        chk("mrst_a", alu_a, 32'(0));
        chk("mrst_tag", 32'(res_tag), 32'(0));
        #2;
        rst_n = 1'b1;
        tick();
        do_op(3'd0, 32'd0, 32'd0, 4'hF, 0, 0, 0);

        chk("sb_left", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
